// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and transfer size codes for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_D_ADDR = 3'd1,
      ST_D_DATA = 3'd2,
      ST_I_ADDR = 3'd3,
      ST_I_DATA = 3'd4
   } arbState_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while a fetch waits; sat forces the next grant to fetch.
// Latency: count and sat update on the clock after inc/clr; clr has priority over inc.
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX);

   logic [STARVE_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store; one transaction at a time, min 3 cycles to data_ok.
// Backpressure: requests wait in IDLE until granted; a low mem_addr_ok holds the address phase indefinitely.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_flush,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stallreq
);

   arbState_t         state;
   logic              reqWr;
   logic [1:0]        reqSize;
   logic [ADDR_W-1:0] reqAddr;
   logic [DATA_W-1:0] reqWdata;
   logic              dropResp;

   logic inIdle;
   logic dataPhase;
   logic starveSat;
   logic grantInst;
   logic grantData;

   assign inIdle    = (state == ST_IDLE);
   assign dataPhase = (state == ST_D_DATA) || (state == ST_I_DATA);

   // Data has priority unless fetch has already lost STARVE_MAX grants in a row.
   assign grantInst = inIdle && inst_req && (!data_req || starveSat);
   assign grantData = inIdle && data_req && !grantInst;

   arb_starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (grantData && inst_req),
      .clr (grantInst || (inIdle && !inst_req)),
      .sat (starveSat)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         reqWr    <= 1'b0;
         reqSize  <= '0;
         reqAddr  <= '0;
         reqWdata <= '0;
         dropResp <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grantInst) begin
                  state    <= ST_I_ADDR;
                  reqWr    <= 1'b0;
                  reqSize  <= SZ_WORD;
                  reqAddr  <= inst_addr;
                  reqWdata <= '0;
               end else if (grantData) begin
                  state    <= ST_D_ADDR;
                  reqWr    <= data_wr;
                  reqSize  <= data_size;
                  reqAddr  <= data_addr;
                  reqWdata <= data_wdata;
               end
            end
            ST_D_ADDR: if (mem_addr_ok) state <= ST_D_DATA;
            ST_D_DATA: if (mem_data_ok) state <= ST_IDLE;
            ST_I_ADDR: begin
               if (inst_flush)  dropResp <= 1'b1;
               if (mem_addr_ok) state    <= ST_I_DATA;
            end
            ST_I_DATA: begin
               // A flushed fetch still has to drain its response from the port.
               if (mem_data_ok) begin
                  state    <= ST_IDLE;
                  dropResp <= 1'b0;
               end else if (inst_flush) begin
                  dropResp <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req   = (state == ST_D_ADDR) || (state == ST_I_ADDR);
   assign mem_wr    = reqWr;
   assign mem_size  = reqSize;
   assign mem_addr  = reqAddr;
   assign mem_wdata = reqWdata;

   assign inst_addr_ok = (state == ST_I_ADDR) && mem_addr_ok;
   assign data_addr_ok = (state == ST_D_ADDR) && mem_addr_ok;
   assign inst_data_ok = (state == ST_I_DATA) && mem_data_ok && !dropResp;
   assign data_data_ok = (state == ST_D_DATA) && mem_data_ok;

   assign inst_rdata = inst_data_ok ? mem_rdata : '0;
   assign data_rdata = data_data_ok ? mem_rdata : '0;

   // Released in the response cycle so the pipeline can capture data_ok and advance together.
   assign stallreq = rst && (inIdle ? (data_req || inst_req) : !(dataPhase && mem_data_ok));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter; a transaction-level model predicts every output each cycle.
module tb_mem_port_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int STARVE = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          inst_req, inst_flush, inst_addr_ok, inst_data_ok;
   logic [AW-1:0] inst_addr;
   logic [DW-1:0] inst_rdata;
   logic          data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]    data_size;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata, data_rdata;
   logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          stallreq;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .stallreq(stallreq)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chkS(input string name, input string act, input string exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   // Transaction-level model: who owns the port (0 none, 1 data, 2 inst) and which phase it is in.
   int          mOwner = 0;
   bit          mAddrPh = 1'b0;
   int          mWait = 0;
   bit          mDrop = 1'b0;
   bit          mWr = 1'b0;
   bit   [1:0]  mSize = 2'd0;
   bit   [31:0] mAddr = 32'd0;
   bit   [31:0] mWdata = 32'd0;
   bit          mInstAcc, mDataAcc;

   task automatic modelUpdate();
      bit instWins;
      mInstAcc = 1'b0;
      mDataAcc = 1'b0;
      if (!rst) begin
         mOwner = 0; mAddrPh = 1'b0; mWait = 0; mDrop = 1'b0;
         mWr = 1'b0; mSize = 2'd0; mAddr = 32'd0; mWdata = 32'd0;
      end else if (mOwner == 0) begin
         instWins = inst_req && (!data_req || mWait >= STARVE);
         if (instWins) begin
            mOwner = 2; mAddrPh = 1'b1; mWr = 1'b0; mSize = 2'd2; mAddr = inst_addr; mWait = 0;
         end else if (data_req) begin
            mOwner = 1; mAddrPh = 1'b1; mWr = data_wr; mSize = data_size;
            mAddr = data_addr; mWdata = data_wdata;
            mWait = inst_req ? ((mWait + 1 > STARVE) ? STARVE : mWait + 1) : 0;
         end else begin
            mWait = 0;
         end
      end else if (mAddrPh) begin
         if (mOwner == 2 && inst_flush) mDrop = 1'b1;
         if (mem_addr_ok) begin
            mAddrPh = 1'b0;
            if (mOwner == 2) mInstAcc = 1'b1; else mDataAcc = 1'b1;
         end
      end else begin
         if (mem_data_ok) begin
            mOwner = 0; mDrop = 1'b0;
         end else if (mOwner == 2 && inst_flush) begin
            mDrop = 1'b1;
         end
      end
   endtask

   // Compare process: every output against the model on each falling edge.
   always @(negedge clk) begin : cmp
      logic eReq, eIA, eDA, eID, eDD, eStall;
      logic [31:0] eIR, eDR;
      eReq   = rst && mOwner != 0 && mAddrPh;
      eIA    = rst && mOwner == 2 && mAddrPh && mem_addr_ok;
      eDA    = rst && mOwner == 1 && mAddrPh && mem_addr_ok;
      eID    = rst && mOwner == 2 && !mAddrPh && mem_data_ok && !mDrop;
      eDD    = rst && mOwner == 1 && !mAddrPh && mem_data_ok;
      eIR    = eID ? mem_rdata : 32'd0;
      eDR    = eDD ? mem_rdata : 32'd0;
      eStall = rst && ((mOwner != 0) ? !(!mAddrPh && mem_data_ok) : (inst_req || data_req));
      chk("mem_req", mem_req, eReq);
      chk("inst_addr_ok", inst_addr_ok, eIA);
      chk("data_addr_ok", data_addr_ok, eDA);
      chk("inst_data_ok", inst_data_ok, eID);
      chk("data_data_ok", data_data_ok, eDD);
      chk("inst_rdata", inst_rdata, eIR);
      chk("data_rdata", data_rdata, eDR);
      chk("stallreq", stallreq, eStall);
      if (!rst || eReq) begin
         chk("mem_wr", mem_wr, rst ? mWr : 1'b0);
         chk("mem_size", mem_size, rst ? mSize : 2'd0);
         chk("mem_addr", mem_addr, rst ? mAddr : 32'd0);
      end
      if (!rst || (eReq && mOwner == 1)) chk("mem_wdata", mem_wdata, rst ? mWdata : 32'd0);
   end

   string       aokLog = "";
   string       evLog = "";
   int          instDok = 0;
   int          dataDok = 0;
   logic [31:0] lastIR = 32'd0;
   logic [31:0] lastDR = 32'd0;

   always @(negedge clk) begin
      if (inst_addr_ok) begin aokLog = {aokLog, "I"}; evLog = {evLog, "I"}; end
      if (data_addr_ok) begin aokLog = {aokLog, "D"}; evLog = {evLog, "D"}; end
      if (inst_data_ok) begin evLog = {evLog, "i"}; instDok++; lastIR = inst_rdata; end
      if (data_data_ok) begin evLog = {evLog, "d"}; dataDok++; lastDR = data_rdata; end
   end

   bit          autoM = 1'b0, keepI = 1'b0, keepD = 1'b0, fixR = 1'b0;
   int          aProb = 100, dProb = 100;
   logic [31:0] rFix = 32'd0;

   // One clock: advance the model at the edge, then drive masters and the memory port.
   task automatic cyc();
      @(posedge clk);
      modelUpdate();
      #1;
      if (mInstAcc && !keepI) inst_req = 1'b0;
      if (mDataAcc && !keepD) data_req = 1'b0;
      if (autoM) begin
         if (!inst_req && $urandom_range(99) < 30) begin
            inst_req = 1'b1; inst_addr = $urandom;
         end
         if (!data_req && $urandom_range(99) < 35) begin
            data_req = 1'b1; data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(2));
            data_addr = $urandom; data_wdata = $urandom;
         end
         inst_flush = ($urandom_range(99) < 8);
      end
      mem_addr_ok = (mOwner != 0) && mAddrPh && ($urandom_range(99) < aProb);
      mem_data_ok = (mOwner != 0) && !mAddrPh && ($urandom_range(99) < dProb);
      mem_rdata   = fixR ? rFix : $urandom;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((mOwner != 0 || inst_req || data_req) && n < 100) begin
         cyc();
         n++;
      end
      chk({name, "_timeout"}, n >= 100, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      inst_req = 0; inst_addr = 0; inst_flush = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

      cyc();
      #2;
      chk("reset_ctl", {mem_req, mem_wr, mem_size, inst_addr_ok, inst_data_ok,
                        data_addr_ok, data_data_ok, stallreq}, 9'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      cyc();
      rst = 1'b1;
      cyc();

      // Single fetch.
      fixR = 1'b1; rFix = 32'h3C1D0001; evLog = "";
      inst_req = 1'b1; inst_addr = 32'hBFC00000;
      cyc();
      cyc();
      #2;
      chk("fetch_data_ok", inst_data_ok, 1'b1);
      chk("fetch_rdata", inst_rdata, 32'h3C1D0001);
      chk("fetch_stall_falls", stallreq, 1'b0);
      chk("fetch_data_side_quiet", {data_addr_ok, data_data_ok, data_rdata}, 34'd0);
      cyc();
      chkS("fetch_events", evLog, "Ii");

      // Collision: store beats fetch.
      fixR = 1'b0; evLog = "";
      inst_req = 1'b1; inst_addr = 32'hBFC00004;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
      data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
      cyc();
      #2;
      chk("collide_mem_wr", mem_wr, 1'b1);
      chk("collide_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("collide_mem_addr", mem_addr, 32'h80000010);
      drain("collide");
      chkS("collide_order", evLog, "DdIi");

      // Starvation with both masters requesting continuously.
      aokLog = ""; keepI = 1'b1; keepD = 1'b1;
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
      for (int n = 0; n < 300 && aokLog.len() < 10; n++) cyc();
      keepI = 1'b0; keepD = 1'b0; inst_req = 1'b0; data_req = 1'b0;
      drain("starve");
      chkS("starve_order", aokLog, "DDDDIDDDDI");

      // Flush while the fetch waits for data.
      fixR = 1'b1; rFix = 32'h12345678; dProb = 0; instDok = 0;
      inst_req = 1'b1; inst_addr = 32'hBFC00100;
      cyc();
      cyc();
      inst_flush = 1'b1;
      cyc();
      inst_flush = 1'b0; dProb = 100;
      cyc();
      #2;
      chk("flush_data_ok", inst_data_ok, 1'b0);
      chk("flush_rdata", inst_rdata, 32'd0);
      cyc();
      #2;
      chk("flush_idle", {mem_req, stallreq}, 2'b00);
      chk("flush_dok_count", instDok, 0);
      rFix = 32'h0000ABCD; inst_req = 1'b1; inst_addr = 32'hBFC00104;
      drain("flush_next");
      chk("flush_next_count", instDok, 1);
      chk("flush_next_rdata", lastIR, 32'h0000ABCD);

      // Port withholds mem_addr_ok.
      aProb = 0; evLog = "";
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h80000040;
      cyc();
      for (int k = 0; k < 10; k++) begin
         #2;
         chk("stall_mem_req", mem_req, 1'b1);
         chk("stall_mem_addr", mem_addr, 32'h80000040);
         chk("stall_stallreq", stallreq, 1'b1);
         chk("stall_no_addr_ok", data_addr_ok, 1'b0);
         cyc();
      end
      aProb = 100;
      drain("stall");
      chkS("stall_events", evLog, "Dd");

      // Reset during a load's data phase.
      dProb = 0;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000080;
      cyc();
      cyc();
      rst = 1'b0;
      #2;
      chk("rst_mid_ctl", {mem_req, mem_wr, mem_size, inst_addr_ok, inst_data_ok,
                          data_addr_ok, data_data_ok, stallreq}, 9'd0);
      chk("rst_mid_mem_addr", mem_addr, 32'd0);
      cyc();
      rst = 1'b1; dProb = 100; rFix = 32'h5A5AA5A5; dataDok = 0;
      data_req = 1'b1; data_addr = 32'h80000000;
      drain("rst_load");
      chk("rst_load_count", dataDok, 1);
      chk("rst_load_rdata", lastDR, 32'h5A5AA5A5);

      // Random traffic with random port latency and flushes.
      fixR = 1'b0; autoM = 1'b1; aProb = 60; dProb = 60;
      repeat (3000) cyc();
      autoM = 1'b0; inst_flush = 1'b0; aProb = 100; dProb = 100;
      drain("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
